// File: rtl/hier_node_sequencer.sv
// Hierarchy node controller: launches the enabled children in parallel or in index order,
// then folds their done/error status into a single completion pulse for the parent.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a run command from the parent
// LAUNCH | one-cycle launch pulse to all children, or to the next child
// WAIT   | collecting child done/err; per-phase timeout runs here
// DONE   | one-cycle aggregated completion pulse to the parent
module hier_node_sequencer #(
  parameter int NUM_CHILDREN   = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    start_ready_o,
  input  logic                    mode_i,
  input  logic [NUM_CHILDREN-1:0] en_mask_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    timeout_o,
  output logic                    aborted_o,
  output logic [NUM_CHILDREN-1:0] done_mask_o,
  output logic [NUM_CHILDREN-1:0] err_mask_o,
  output logic [IDX_W-1:0]        cur_idx_o,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  input  logic [NUM_CHILDREN-1:0] child_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_DONE} state_e;

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               TMR_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMR_LOAD = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                  state_q;
  logic                    mode_q;
  logic [NUM_CHILDREN-1:0] en_q;
  logic [NUM_CHILDREN-1:0] launched_q;
  logic [NUM_CHILDREN-1:0] done_mask_q;
  logic [NUM_CHILDREN-1:0] err_mask_q;
  logic [NUM_CHILDREN-1:0] child_start_q;
  logic [IDX_W-1:0]        cur_idx_q;
  logic [CNT_W-1:0]        tmr_q;
  logic                    done_q;
  logic                    err_q;
  logic                    timeout_q;
  logic                    aborted_q;

  logic                    active;
  logic [NUM_CHILDREN-1:0] pending;
  logic [NUM_CHILDREN-1:0] accept;
  logic [NUM_CHILDREN-1:0] done_mask_d;
  logic [NUM_CHILDREN-1:0] err_mask_d;
  logic [NUM_CHILDREN-1:0] remain_d;
  logic [NUM_CHILDREN-1:0] pending_d;
  logic [NUM_CHILDREN-1:0] launch_src;
  logic [NUM_CHILDREN-1:0] launch_oh;
  logic                    launch_seq;
  logic [IDX_W-1:0]        launch_idx;
  logic                    tmr_hit;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CHILDREN-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Only children that were launched and have not yet finished may report done.
  always_comb begin
    active      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    pending     = launched_q & ~done_mask_q;
    accept      = active ? (child_done_i & pending) : '0;
    done_mask_d = done_mask_q | accept;
    err_mask_d  = err_mask_q | (child_err_i & accept);
    remain_d    = en_q & ~done_mask_d;
    pending_d   = launched_q & ~done_mask_d;
    tmr_hit     = TMR_EN && (tmr_q == '0) && (|pending);
    if (state_q == ST_IDLE) begin
      launch_src = en_mask_i;
      launch_seq = mode_i;
    end else begin
      launch_src = remain_d;
      launch_seq = mode_q;
    end
    launch_oh  = launch_seq ? (launch_src & (~launch_src + 1'b1)) : launch_src;
    launch_idx = launch_seq ? lowest_idx(launch_src) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      en_q          <= '0;
      launched_q    <= '0;
      done_mask_q   <= '0;
      err_mask_q    <= '0;
      child_start_q <= '0;
      cur_idx_q     <= '0;
      tmr_q         <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      child_start_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      aborted_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q      <= mode_i;
            en_q        <= en_mask_i;
            done_mask_q <= '0;
            err_mask_q  <= '0;
            tmr_q       <= '0;
            if (en_mask_i == '0) begin
              launched_q <= '0;
              cur_idx_q  <= '0;
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
            end else begin
              launched_q    <= launch_oh;
              child_start_q <= launch_oh;
              cur_idx_q     <= launch_idx;
              state_q       <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          done_mask_q <= done_mask_d;
          err_mask_q  <= err_mask_d;
          tmr_q       <= TMR_LOAD;
          if (abort_i) begin
            state_q   <= ST_DONE;
            cur_idx_q <= '0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          done_mask_q <= done_mask_d;
          err_mask_q  <= err_mask_d;
          // Abort beats timeout, and timeout beats a completion landing in the same cycle.
          if (abort_i) begin
            state_q   <= ST_DONE;
            cur_idx_q <= '0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            aborted_q <= 1'b1;
          end else if (tmr_hit) begin
            state_q   <= ST_DONE;
            cur_idx_q <= '0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else if (remain_d == '0) begin
            state_q   <= ST_DONE;
            cur_idx_q <= '0;
            done_q    <= 1'b1;
            err_q     <= |err_mask_d;
          end else if (mode_q && (pending_d == '0)) begin
            launched_q    <= launched_q | launch_oh;
            child_start_q <= launch_oh;
            cur_idx_q     <= launch_idx;
            state_q       <= ST_LAUNCH;
          end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready_o = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign timeout_o     = timeout_q;
  assign aborted_o     = aborted_q;
  assign done_mask_o   = done_mask_q;
  assign err_mask_o    = err_mask_q;
  assign cur_idx_o     = cur_idx_q;
  assign child_start_o = child_start_q;

endmodule

// File: tb/tb_hier_node_sequencer.sv
// Directed bench for hier_node_sequencer: scripted child responders, per-scenario
// tasks with hand-derived expected launch order, cycle of done_o and status flags.
module tb_hier_node_sequencer;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         start_ready_o;
  logic         mode_i;
  logic [N-1:0] en_mask_i;
  logic         abort_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic         timeout_o;
  logic         aborted_o;
  logic [N-1:0] done_mask_o;
  logic [N-1:0] err_mask_o;
  logic [2:0]   cur_idx_o;
  logic [N-1:0] child_start_o;
  logic [N-1:0] child_done_i;
  logic [N-1:0] child_err_i;

  always #5 clk = ~clk;

  hier_node_sequencer #(.NUM_CHILDREN(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_ready_o(start_ready_o),
    .mode_i(mode_i), .en_mask_i(en_mask_i), .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o), .aborted_o(aborted_o),
    .done_mask_o(done_mask_o), .err_mask_o(err_mask_o), .cur_idx_o(cur_idx_o),
    .child_start_o(child_start_o), .child_done_i(child_done_i), .child_err_i(child_err_i)
  );

  int n_pass = 0;
  int n_total = 0;

  // responder script
  int           lat[N];
  logic [N-1:0] err_sel;
  logic [N-1:0] spur_m;
  int           spur_c;
  int           abort_c;

  // observations of the last run
  int           n_launch;
  int           n_done;
  int           done_cyc;
  logic [N-1:0] l_val[8];
  logic [2:0]   l_idx[8];
  logic         d_err, d_to, d_ab;
  logic [N-1:0] d_dmask, d_emask;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) lat[i] = 0;
    err_sel = '0;
    spur_m  = '0;
    spur_c  = -1;
    abort_c = -1;
  endtask

  task automatic do_start(input logic m, input logic [N-1:0] msk);
    start_i   = 1'b1;
    mode_i    = m;
    en_mask_i = msk;
    step();
    start_i   = 1'b0;
    mode_i    = 1'b0;
    en_mask_i = '0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic run(input int ncyc);
    int sched[N];
    for (int i = 0; i < N; i++) sched[i] = -1;
    n_launch = 0; n_done = 0; done_cyc = -1;
    d_err = 1'b0; d_to = 1'b0; d_ab = 1'b0; d_dmask = '0; d_emask = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (child_start_o != '0) begin
        if (n_launch < 8) begin
          l_val[n_launch] = child_start_o;
          l_idx[n_launch] = cur_idx_o;
        end
        n_launch++;
        for (int i = 0; i < N; i++)
          if (child_start_o[i] && lat[i] > 0) sched[i] = c + lat[i];
      end
      if (done_o) begin
        n_done++;
        done_cyc = c;
        d_err = err_o; d_to = timeout_o; d_ab = aborted_o;
        d_dmask = done_mask_o; d_emask = err_mask_o;
      end
      for (int i = 0; i < N; i++) begin
        child_done_i[i] = (sched[i] == c);
        child_err_i[i]  = err_sel[i] && (sched[i] == c);
      end
      if (c == spur_c) child_done_i = child_done_i | spur_m;
      abort_i = (c == abort_c);
      step();
    end
    child_done_i = '0;
    child_err_i  = '0;
    abort_i      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0; mode_i = 1'b0; en_mask_i = '0; abort_i = 1'b0;
    child_done_i = '0; child_err_i = '0;
    clear_stim();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (start_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", start_ready_o); else n_pass++;
    n_total++; if ({busy_o, done_o, err_o, timeout_o, aborted_o} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, err_o, timeout_o, aborted_o}); else n_pass++;
    n_total++; if ({done_mask_o, err_mask_o, child_start_o, cur_idx_o} !== 18'h0)
      $display("FAIL reset_vectors: got %h want 0", {done_mask_o, err_mask_o, child_start_o, cur_idx_o}); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_parallel();
    clear_stim();
    lat[1] = 3; lat[2] = 7; lat[4] = 5;
    do_start(1'b0, 5'b10110);
    n_total++; if ({busy_o, start_ready_o} !== 2'b10) $display("FAIL par_busy: got %b want 10", {busy_o, start_ready_o}); else n_pass++;
    run(14);
    n_total++; if (n_launch !== 1) $display("FAIL par_launch_cnt: got %0d want 1", n_launch); else n_pass++;
    n_total++; if (l_val[0] !== 5'b10110) $display("FAIL par_launch_val: got %b want 10110", l_val[0]); else n_pass++;
    n_total++; if (l_idx[0] !== 3'd0) $display("FAIL par_cur_idx: got %0d want 0", l_idx[0]); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL par_done_cnt: got %0d want 1", n_done); else n_pass++;
    n_total++; if (done_cyc !== 9) $display("FAIL par_done_cycle: got %0d want 9", done_cyc); else n_pass++;
    n_total++; if (d_dmask !== 5'b10110) $display("FAIL par_done_mask: got %b want 10110", d_dmask); else n_pass++;
    n_total++; if (d_err !== 1'b0) $display("FAIL par_err: got %b want 0", d_err); else n_pass++;
    n_total++; if (start_ready_o !== 1'b1) $display("FAIL par_idle_after: got %b want 1", start_ready_o); else n_pass++;
  endtask

  task automatic test_sequential();
    clear_stim();
    lat[0] = 2; lat[3] = 2; lat[4] = 2;
    do_start(1'b1, 5'b11001);
    run(14);
    n_total++; if (n_launch !== 3) $display("FAIL seq_launch_cnt: got %0d want 3", n_launch); else n_pass++;
    n_total++; if ({l_val[0], l_val[1], l_val[2]} !== {5'b00001, 5'b01000, 5'b10000})
      $display("FAIL seq_launch_val: got %b %b %b want 00001 01000 10000", l_val[0], l_val[1], l_val[2]); else n_pass++;
    n_total++; if ({l_idx[0], l_idx[1], l_idx[2]} !== {3'd0, 3'd3, 3'd4})
      $display("FAIL seq_cur_idx: got %0d %0d %0d want 0 3 4", l_idx[0], l_idx[1], l_idx[2]); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL seq_done_cnt: got %0d want 1", n_done); else n_pass++;
    n_total++; if (done_cyc !== 10) $display("FAIL seq_done_cycle: got %0d want 10", done_cyc); else n_pass++;
    n_total++; if ({d_dmask, d_err} !== {5'b11001, 1'b0})
      $display("FAIL seq_status: got %b/%b want 11001/0", d_dmask, d_err); else n_pass++;
  endtask

  task automatic test_timeout();
    clear_stim();
    lat[0] = 2;
    do_start(1'b0, 5'b00011);
    run(22);
    n_total++; if (n_done !== 1) $display("FAIL to_done_cnt: got %0d want 1", n_done); else n_pass++;
    n_total++; if (done_cyc !== 18) $display("FAIL to_done_cycle: got %0d want 18", done_cyc); else n_pass++;
    n_total++; if ({d_to, d_err, d_ab} !== 3'b110) $display("FAIL to_flags: got %b want 110", {d_to, d_err, d_ab}); else n_pass++;
    n_total++; if (d_dmask !== 5'b00001) $display("FAIL to_done_mask: got %b want 00001", d_dmask); else n_pass++;
    n_total++; if ({timeout_o, err_o} !== 2'b00) $display("FAIL to_flags_held: got %b want 00", {timeout_o, err_o}); else n_pass++;
  endtask

  task automatic test_child_error();
    clear_stim();
    lat[0] = 2; lat[2] = 4; err_sel = 5'b00100;
    spur_c = 3; spur_m = 5'b00010;
    do_start(1'b0, 5'b00101);
    run(10);
    n_total++; if (done_cyc !== 6) $display("FAIL err_done_cycle: got %0d want 6", done_cyc); else n_pass++;
    n_total++; if (d_emask !== 5'b00100) $display("FAIL err_err_mask: got %b want 00100", d_emask); else n_pass++;
    n_total++; if (d_dmask !== 5'b00101) $display("FAIL err_done_mask: got %b want 00101", d_dmask); else n_pass++;
    n_total++; if ({d_err, d_to, d_ab} !== 3'b100) $display("FAIL err_flags: got %b want 100", {d_err, d_to, d_ab}); else n_pass++;
  endtask

  task automatic test_abort();
    clear_stim();
    lat[0] = 3; lat[1] = 3; lat[2] = 3;
    abort_c = 6;
    do_start(1'b1, 5'b00111);
    run(12);
    n_total++; if (done_cyc !== 7) $display("FAIL ab_done_cycle: got %0d want 7", done_cyc); else n_pass++;
    n_total++; if ({d_ab, d_err, d_to} !== 3'b110) $display("FAIL ab_flags: got %b want 110", {d_ab, d_err, d_to}); else n_pass++;
    n_total++; if (n_launch !== 2) $display("FAIL ab_launch_cnt: got %0d want 2", n_launch); else n_pass++;
    n_total++; if (l_idx[1] !== 3'd1) $display("FAIL ab_cur_idx: got %0d want 1", l_idx[1]); else n_pass++;
    n_total++; if (done_mask_o !== 5'b00001) $display("FAIL ab_mask_held: got %b want 00001", done_mask_o); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int seen;
    clear_stim();
    do_start(1'b0, 5'b00011);
    n_total++; if (child_start_o !== 5'b00011) $display("FAIL rst_launch: got %b want 00011", child_start_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({child_start_o, busy_o, start_ready_o} !== 7'b0000001)
      $display("FAIL rst_async_drop: got %b want 0000001", {child_start_o, busy_o, start_ready_o}); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    do_start(1'b0, 5'b00011);
    child_done_i = 5'b00001;
    step();
    child_done_i = '0;
    step();
    n_total++; if (done_mask_o !== 5'b00001) $display("FAIL rst_pre_mask: got %b want 00001", done_mask_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({done_mask_o, busy_o} !== 6'b0) $display("FAIL rst_wait_clear: got %b want 000000", {done_mask_o, busy_o}); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_o) seen++;
      step();
    end
    n_total++; if (seen !== 0) $display("FAIL rst_no_done: got %0d done pulses want 0", seen); else n_pass++;

    start_i = 1'b1; en_mask_i = '0;
    step();
    n_total++; if ({done_o, err_o, start_ready_o} !== 3'b100)
      $display("FAIL empty_done: got %b want 100", {done_o, err_o, start_ready_o}); else n_pass++;
    en_mask_i = 5'b00001;
    step();
    start_i = 1'b0; en_mask_i = '0;
    n_total++; if ({child_start_o, busy_o, start_ready_o} !== 7'b0000001)
      $display("FAIL start_in_done_ignored: got %b want 0000001", {child_start_o, busy_o, start_ready_o}); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_sequential();
    test_timeout();
    test_child_error();
    test_abort();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
